// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the FIFO pointer/flag controller.
//   DEF_QUEUE_SIZE     default pointer width
//   FIFO_DEPTH         default depth, 2**DEF_QUEUE_SIZE
//   DEF_ALMOST_FULL    default almost-full threshold (count >= threshold)
//   DEF_ALMOST_EMPTY   default almost-empty threshold (count <= threshold)
//   count_width()      occupancy width for a given pointer width
package fifo_pkg;
  localparam int DEF_QUEUE_SIZE   = 3;
  localparam int FIFO_DEPTH       = 2 ** DEF_QUEUE_SIZE;
  localparam int DEF_ALMOST_FULL  = 6;
  localparam int DEF_ALMOST_EMPTY = 1;

  // One extra bit so a completely full FIFO (count == depth) is representable.
  function automatic int count_width(input int ptr_width);
    return ptr_width + 1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping RAM address register.
//   clk    in   clock, posedge
//   reset  in   synchronous active-high clear to 0
//   inc    in   advance pointer by one this cycle
//   ptr    out  current address, wraps modulo 2**W
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = DEF_QUEUE_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for the main FIFO RAM.
//   clk, reset        clock (posedge) and synchronous active-high reset
//   push, pop         store / read request for this cycle
//   write, read       RAM write/read enables (accepted requests, combinational)
//   wr_ptr, rd_ptr    RAM write/read addresses
//   data_valid        RAM read data valid, one cycle after read
//   fifo_count        occupancy 0..2**MAIN_QUEUE_SIZE
//   full, empty       registered occupancy flags
//   almost_full       registered, count >= ALMOST_FULL
//   almost_empty      registered, count <= ALMOST_EMPTY
//   overflow          sticky rejected-push flag
//   underflow         sticky rejected-pop flag
// Build option: define FIFO_CTRL_ERR_FLAGS_EN to enable overflow/underflow;
// otherwise both outputs are tied low.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int MAIN_QUEUE_SIZE = DEF_QUEUE_SIZE,
  parameter int ALMOST_FULL     = DEF_ALMOST_FULL,
  parameter int ALMOST_EMPTY    = DEF_ALMOST_EMPTY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  output logic                       write,
  output logic                       read,
  output logic [MAIN_QUEUE_SIZE-1:0] wr_ptr,
  output logic [MAIN_QUEUE_SIZE-1:0] rd_ptr,
  output logic                       data_valid,
  output logic [MAIN_QUEUE_SIZE:0]   fifo_count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW    = count_width(MAIN_QUEUE_SIZE);
  localparam int DEPTH = 2 ** MAIN_QUEUE_SIZE;

  logic          pop_ok;
  logic          push_ok;
  logic [CW-1:0] count_nxt;

  // Reset overrides requests so the RAM sees no enables while clearing.
  // A push into a full FIFO is allowed when a pop frees a slot the same cycle.
  assign pop_ok  = pop & ~empty & ~reset;
  assign push_ok = push & (~full | pop_ok) & ~reset;
  assign write   = push_ok;
  assign read    = pop_ok;

  assign count_nxt = fifo_count + CW'(push_ok) - CW'(pop_ok);

  fifo_ptr #(.W(MAIN_QUEUE_SIZE)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(MAIN_QUEUE_SIZE)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  // Flags come from the next count so they line up with fifo_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      data_valid   <= 1'b0;
    end else begin
      fifo_count   <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(ALMOST_FULL));
      almost_empty <= (count_nxt <= CW'(ALMOST_EMPTY));
      data_valid   <= pop_ok;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & ~push_ok)
        overflow <= 1'b1;
      if (pop & empty)
        underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed plus random stimulus for fifo_ctrl. A behavioural
// queue model predicts acceptance, occupancy and flags; a small RAM beside the
// DUT returns data, and a monitor checks each data_valid word against the
// expected-data queue filled when the model accepts a pop.
module tb_fifo_ctrl;
  localparam int N     = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic         clk = 1'b0;
  logic         reset, push, pop;
  logic         write, read, data_valid;
  logic [N-1:0] wr_ptr, rd_ptr;
  logic [N:0]   fifo_count;
  logic         full, empty, almost_full, almost_empty, overflow, underflow;

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata;
  logic [7:0] wdata;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model
  int m_items[$];
  int exp_q[$];
  int m_pushes = 0, m_pops = 0;
  int m_dv = 0, m_ovf = 0, m_unf = 0;
  int next_val = 0;

  fifo_ctrl #(.MAIN_QUEUE_SIZE(N), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .data_valid   (data_valid),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // RAM beside the DUT: read-before-write on the same address.
  always @(posedge clk) begin
    if (read)  rdata <= mem[rd_ptr];
    if (write) mem[wr_ptr] <= wdata;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented word must match the oldest expected word.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0)
        chk("data_valid_unexpected", 1, 0);
      else
        chk("rdata", int'(rdata), exp_q.pop_front());
    end
  end

  // One clock: drive at negedge, check enables, update model at posedge,
  // check registered outputs at the next negedge.
  task automatic cycle(input bit p, input bit q, input bit r);
    int  cnt;
    bit  pop_acc, push_acc;
    cnt      = m_items.size();
    pop_acc  = q && !r && cnt > 0;
    push_acc = p && !r && (cnt < DEPTH || pop_acc);
    push  = p;
    pop   = q;
    reset = r;
    wdata = 8'(next_val);
    #1;
    chk("write", int'(write), int'(push_acc));
    chk("read",  int'(read),  int'(pop_acc));
    @(posedge clk);
    if (r) begin
      m_items.delete();
      m_pushes = 0; m_pops = 0; m_dv = 0; m_ovf = 0; m_unf = 0;
    end else begin
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      if (p && !push_acc) m_ovf = 1;
      if (q && cnt == 0)  m_unf = 1;
`endif
      if (pop_acc) begin
        exp_q.push_back(m_items.pop_front());
        m_pops++;
      end
      if (push_acc) begin
        m_items.push_back(next_val);
        next_val = (next_val + 1) % 256;
        m_pushes++;
      end
      m_dv = pop_acc ? 1 : 0;
    end
    @(negedge clk);
    cnt = m_items.size();
    chk("wr_ptr",       int'(wr_ptr),       m_pushes % DEPTH);
    chk("rd_ptr",       int'(rd_ptr),       m_pops % DEPTH);
    chk("fifo_count",   int'(fifo_count),   cnt);
    chk("full",         int'(full),         int'(cnt == DEPTH));
    chk("empty",        int'(empty),        int'(cnt == 0));
    chk("almost_full",  int'(almost_full),  int'(cnt >= AF));
    chk("almost_empty", int'(almost_empty), int'(cnt <= AE));
    chk("data_valid",   int'(data_valid),   m_dv);
    chk("overflow",     int'(overflow),     m_ovf);
    chk("underflow",    int'(underflow),    m_unf);
  endtask

  initial begin
    int bias;
    reset = 1'b1; push = 1'b1; pop = 1'b1; wdata = '0;
    // reset held with requests active
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    // fill, then push into full
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    cycle(1, 0, 0);
    // drain in order, then pop from empty
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 1);
    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);
    // empty with simultaneous push and pop
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    // build to count 5, then reset mid-operation
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    // random traffic with drifting fill bias and rare resets
    bias = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) bias = $urandom_range(15, 85);
      cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10,
            $urandom_range(0, 99) == 0);
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
